// File: rtl/demux1to3_stream_if.sv
// ---------------------------------------------------------------------------
// demux1to3_stream_if
// Bundle of the stream signals around the 1-to-3 demultiplexer.
//   in_valid/in_ready/in_sel/in_data : upstream stream with 2-bit destination
//   outN_valid/outN_ready/outN_data  : the three downstream channels (N=0..2)
// Modports:
//   master : the environment side. It drives the input stream and the
//            consumer readies, and observes in_ready and the channel outputs.
//   slave  : the demultiplexer side.
// ---------------------------------------------------------------------------
interface demux1to3_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;

  modport master (
    output in_valid, in_sel, in_data,
    input  in_ready,
    input  out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data,
    output out0_ready, out1_ready, out2_ready
  );

  modport slave (
    input  in_valid, in_sel, in_data,
    output in_ready,
    output out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data,
    input  out0_ready, out1_ready, out2_ready
  );
endinterface

// File: rtl/demux1to3_stream.sv
// ---------------------------------------------------------------------------
// demux1to3_stream
// Registered 1-to-3 stream demultiplexer. Each accepted input word goes to
// one of three channels, selected by in_sel. Every channel has a 1-entry
// output register with its own back-pressure. A select of 3 is illegal: the
// word is taken and dropped, and the error is recorded.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   s         : stream interface (slave modport), with the input stream and
//               the out0..out2 channels
//   err_clr   : synchronous clear of err_flag and err_count
//   err_flag  : sticky flag, set when an illegal select was accepted
//   err_count : count of illegal selects accepted; saturates at all-ones
// ---------------------------------------------------------------------------
module demux1to3_stream #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux1to3_stream_if.slave    s,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [2:0]       out_ready_w;
  logic [2:0]       free_w;
  logic             in_ready_w;
  logic             accept_w;
  logic             illegal_acc_w;

  assign out_ready_w = {s.out2_ready, s.out1_ready, s.out0_ready};

  // in_ready depends only on the select and the channel state, never on
  // in_valid. An illegal select is always taken so that it cannot stall
  // the upstream source.
  always_comb begin
    in_ready_w = 1'b1;
    case (s.in_sel)
      2'd0:    in_ready_w = free_w[0];
      2'd1:    in_ready_w = free_w[1];
      2'd2:    in_ready_w = free_w[2];
      default: in_ready_w = 1'b1;
    endcase
  end

  assign s.in_ready    = in_ready_w;
  assign accept_w      = s.in_valid && in_ready_w;
  assign illegal_acc_w = accept_w && (s.in_sel == 2'd3);

  // One output register per channel. A channel is free when it is empty or
  // its word leaves this cycle. This allows a load and a drain in the same
  // cycle, which gives one word per cycle per channel.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic             load_w;
      logic             valid_q;
      logic             valid_d;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;

      assign free_w[gi] = !valid_q || out_ready_w[gi];
      assign load_w     = accept_w && (s.in_sel == 2'(gi));

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_w) begin
          valid_d = 1'b1;
          data_d  = s.in_data;
        end else if (valid_q && out_ready_w[gi]) begin
          // Drain only. The data keeps its last value.
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end
  endgenerate

  assign s.out0_valid = g_chan[0].valid_q;
  assign s.out0_data  = g_chan[0].data_q;
  assign s.out1_valid = g_chan[1].valid_q;
  assign s.out1_data  = g_chan[1].data_q;
  assign s.out2_valid = g_chan[2].valid_q;
  assign s.out2_data  = g_chan[2].data_q;

  // Error tracking. When a clear and an illegal accept happen in the same
  // cycle, the new error wins, and the count restarts at one.
  logic                 err_flag_q;
  logic                 err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;

  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (illegal_acc_w) begin
      err_flag_d = 1'b1;
      if (err_clr) begin
        err_count_d = ERR_CNT_W'(1);
      end else if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_demux1to3_stream.sv
module tb_demux1to3_stream;
  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       err_flag;
  logic [7:0] err_count;
  logic       err_clr2;
  logic       err_flag2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  demux1to3_stream_if #(.WIDTH(8)) bus ();
  demux1to3_stream_if #(.WIDTH(8)) bus2 ();

  demux1to3_stream #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s(bus), .err_clr(err_clr),
    .err_flag(err_flag), .err_count(err_count)
  );

  // Second instance that uses a narrow counter to test saturation.
  demux1to3_stream #(.WIDTH(8), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .s(bus2), .err_clr(err_clr2),
    .err_flag(err_flag2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the active edge. Checks are made after that
  // point, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // State right after the initial reset.
    checks++;
    if ({bus.out0_valid, bus.out1_valid, bus.out2_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valids got %b exp 000", {bus.out0_valid, bus.out1_valid, bus.out2_valid});
    end
    checks++;
    if (err_flag !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err got flag=%b cnt=%0d exp flag=0 cnt=0", err_flag, err_count);
    end
    checks++;
    if (bus.out1_data !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h exp 00", bus.out1_data);
    end
    // Fill all three channels while they are stalled, then send one illegal word.
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0; bus.in_data = 8'h11; step();
    bus.in_sel = 2'd1; bus.in_data = 8'h22; step();
    bus.in_sel = 2'd2; bus.in_data = 8'h33; step();
    bus.in_sel = 2'd3; bus.in_data = 8'h44; step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out0_valid, bus.out1_valid, bus.out2_valid} !== 3'b111 || err_count !== 8'd1) begin
      errors++; $display("FAIL prefill got v=%b cnt=%0d exp v=111 cnt=1", {bus.out0_valid, bus.out1_valid, bus.out2_valid}, err_count);
    end
    // Assert reset in the middle of the cycle. It must take effect before the next edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out0_valid, bus.out1_valid, bus.out2_valid} !== 3'b000 || err_count !== 8'd0 || err_flag !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b flag=%b cnt=%0d exp v=000 flag=0 cnt=0",
                         {bus.out0_valid, bus.out1_valid, bus.out2_valid}, err_flag, err_count);
    end
    step();
    rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_basic_route();
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'hA5;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_in_ready got %b exp 1", bus.in_ready);
    end
    step();
    bus.in_data = 8'h3C;
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hA5) begin
      errors++; $display("FAIL basic_route got v=%b d=%h exp v=1 d=a5", bus.out1_valid, bus.out1_data);
    end
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
      errors++; $display("FAIL basic_others got v0=%b v2=%b exp 0 0", bus.out0_valid, bus.out2_valid);
    end
    $display("route: sel=1 data=a5 -> out1=%h", bus.out1_data);
  endtask

  task automatic test_backpressure();
    // out1 is full and stalled, and 0x3C is waiting with sel=1.
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready);
    end
    step();
    checks++;
    if (bus.out1_data !== 8'hA5 || bus.out1_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=a5", bus.out1_valid, bus.out1_data);
    end
    bus.out1_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out1_data !== 8'h3C || bus.out1_valid !== 1'b1) begin
      errors++; $display("FAIL bp_load got v=%b d=%h exp v=1 d=3c", bus.out1_valid, bus.out1_data);
    end
    step();
    checks++;
    if (bus.out1_valid !== 1'b0 || bus.out1_data !== 8'h3C) begin
      errors++; $display("FAIL bp_drain got v=%b d=%h exp v=0 d=3c", bus.out1_valid, bus.out1_data);
    end
    bus.out1_ready = 1'b0;
    $display("backpressure: 3c delivered after stall");
  endtask

  task automatic test_throughput();
    bus.out2_ready = 1'b1;
    bus.in_sel = 2'd2;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_data = 8'(i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL tput_ready[%0d] got %b exp 1", i, bus.in_ready);
      end
      step();
      checks++;
      if (bus.out2_valid !== 1'b1 || bus.out2_data !== 8'(i)) begin
        errors++; $display("FAIL tput_data[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out2_valid, bus.out2_data, 8'(i));
      end
      $display("throughput: word %0d out2=%h", i, bus.out2_data);
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out2_valid !== 1'b0) begin
      errors++; $display("FAIL tput_empty got %b exp 0", bus.out2_valid);
    end
    bus.out2_ready = 1'b0;
  endtask

  task automatic test_independent();
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h55;
    step();
    bus.in_sel = 2'd2; bus.in_data = 8'h66;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL indep_ready got %b exp 1", bus.in_ready);
    end
    step();
    bus.in_sel = 2'd0; bus.in_data = 8'h77;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL indep_stalled_ready got %b exp 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h55 || bus.out2_valid !== 1'b1 || bus.out2_data !== 8'h66) begin
      errors++; $display("FAIL indep_hold got v0=%b d0=%h v2=%b d2=%h exp 1 55 1 66",
                         bus.out0_valid, bus.out0_data, bus.out2_valid, bus.out2_data);
    end
    bus.out0_ready = 1'b1; bus.out2_ready = 1'b1;
    step();
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
      errors++; $display("FAIL indep_drain got v0=%b v2=%b exp 0 0", bus.out0_valid, bus.out2_valid);
    end
    bus.out0_ready = 1'b0; bus.out2_ready = 1'b0;
    $display("independent: out0 stalled, out2 accepted");
  endtask

  task automatic test_illegal();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL illegal_preclear got flag=%b cnt=%0d exp 0 0", err_flag, err_count);
    end
    bus.in_valid = 1'b1; bus.in_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(8'hE0 + i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_ready[%0d] got %b exp 1", i, bus.in_ready);
      end
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (err_flag !== 1'b1 || err_count !== 8'd3) begin
      errors++; $display("FAIL illegal_count got flag=%b cnt=%0d exp 1 3", err_flag, err_count);
    end
    checks++;
    if ({bus.out0_valid, bus.out1_valid, bus.out2_valid} !== 3'b000) begin
      errors++; $display("FAIL illegal_no_out got %b exp 000", {bus.out0_valid, bus.out1_valid, bus.out2_valid});
    end
    // A clear and an illegal accept in the same cycle: the error wins.
    bus.in_valid = 1'b1; err_clr = 1'b1;
    step();
    bus.in_valid = 1'b0; err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL clr_with_err got flag=%b cnt=%0d exp 1 1", err_flag, err_count);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL clr_only got flag=%b cnt=%0d exp 0 0", err_flag, err_count);
    end
    $display("illegal: 3 drops counted, clear behaviour ok");
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    bus2.in_valid = 1'b1; bus2.in_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      bus2.in_data = 8'(i);
      step();
      checks++;
      if (err_count2 !== exp_cnt[i] || err_flag2 !== 1'b1) begin
        errors++; $display("FAIL sat_count[%0d] got flag=%b cnt=%0d exp 1 %0d", i, err_flag2, err_count2, exp_cnt[i]);
      end
      $display("saturate: illegal %0d count=%0d", i + 1, err_count2);
    end
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0; err_clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 8'h00;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_sel = 2'd0; bus2.in_data = 8'h00;
    bus2.out0_ready = 1'b0; bus2.out1_ready = 1'b0; bus2.out2_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic_route();
    test_backpressure();
    test_throughput();
    test_independent();
    test_illegal();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1to3_stream.md
Name: demux1to3_stream

Overview:
- Registered 1-to-3 stream demultiplexer; the routing counterpart of the 3-to-1 selector.
- Accepts one valid/ready input stream tagged with a 2-bit destination select.
- Delivers each accepted word to one of three independently back-pressured output channels through a 1-entry output register per channel.
- Sits between the execute/write-back source and three consumer paths; reports illegal selects.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  2  destination: 0→out0, 1→out1, 2→out2, 3→illegal.
- in_data  input  WIDTH  input payload.
- out0_valid, out1_valid, out2_valid  output  1 each  channel holds a word.
- out0_ready, out1_ready, out2_ready  input  1 each  consumer takes the word this cycle.
- out0_data, out1_data, out2_data  output  WIDTH each  channel payload (registered).
- err_flag  output  1  sticky: an illegal select was accepted.
- err_count  output  ERR_CNT_W  number of illegal selects accepted; saturates at all-ones.
- err_clr  input  1  synchronous clear of err_flag and err_count.

Behaviour:
- Reset (async, immediate on rst high): all outN_valid=0, outN_data=0, err_flag=0, err_count=0. Registered state holds while rst is high.
- Channel N is free when !outN_valid || outN_ready.
- in_ready is combinational, from in_sel and channel state:
  - sel 0..2: in_ready = free of the selected channel.
  - sel 3: in_ready = 1.
  - in_ready is independent of in_valid.
- Accept = in_valid && in_ready, evaluated at the rising edge.
- Legal accept to channel N: outN_data <= in_data and outN_valid <= 1. Latency is 1 cycle from accept to outN_valid.
- Channel N drain without a new load: outN_valid && outN_ready → outN_valid <= 0. outN_data holds its last value.
- Simultaneous drain and load on channel N: the new word loads and outN_valid stays 1. This gives full throughput of one word per cycle per channel.
- Non-selected channels:
  - Unaffected by input activity.
  - Drain independently every cycle.
  - All three may hold words and drain at once.
- outN_valid and outN_data are stable while outN_valid && !outN_ready; no word is lost or duplicated.
- Illegal accept (sel 3):
  - Word dropped; no channel changes.
  - err_flag <= 1.
  - err_count <= err_count+1 unless already all-ones; saturates with no wrap.
- err_clr:
  - err_clr without an illegal accept in the same cycle: err_flag <= 0, err_count <= 0.
  - err_clr with an illegal accept in the same cycle: err_flag <= 1, err_count <= 1 (the error wins).
- Ordering: per-channel order is preserved. There is no ordering guarantee across channels.
- in_sel and in_data are don't-care when in_valid=0.
- Reset mid-transfer: held words are discarded and valids cleared.

Test Plan:
- Reset: assert rst mid-cycle with all three channels holding words → all outN_valid=0, err_count=0 immediately, before the next clock edge.
- Basic route: in_sel=1, in_data=0xA5, in_valid=1, out1_ready=0 → next cycle out1_valid=1, out1_data=0xA5, out0/out2_valid=0.
- Back-pressure: following the basic-route case, hold out1_ready=0 and present sel=1 data 0x3C → in_ready=0 and out1_data stays 0xA5. Then set out1_ready=1 → 0x3C is accepted in that same cycle and out1_data=0x3C the next cycle.
- Full throughput: stream 0x01..0x10 to sel=2 with out2_ready=1 constantly → in_ready=1 every cycle; out2_data sequence 0x01..0x10 on consecutive cycles with no gaps.
- Independent channels: fill out0 (ready=0), then send a word to sel=2 → accepted despite out0 being stalled, and out2_valid=1.
- Illegal select and counter:
  - 3 words with sel=3 → err_flag=1, err_count=3, no outN_valid.
  - With ERR_CNT_W=2, 5 illegal words → err_count=3 (saturated).
  - err_clr together with an illegal accept → err_flag=1, err_count=1.
